// File: rtl/rect_fetch_pkg.sv
// Shared types for rect_fetch_ctrl: FSM states, tuple layout and round-robin pick.
// Pure declarations; no latency or backpressure of its own.
package rect_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int RECT_WORDS  = 4;
    localparam int RECT_W_DATA = 5;

    localparam int X = 0;
    localparam int Y = 1;
    localparam int W = 2;
    localparam int H = 3;

    typedef struct packed {
        logic [RECT_W_DATA-1:0] x;
        logic [RECT_W_DATA-1:0] y;
        logic [RECT_W_DATA-1:0] w;
        logic [RECT_W_DATA-1:0] h;
    } rect_t;

    // On a tie the requester that did not win last time gets the grant.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] g;
        g = req;
        if (req == 2'b11)
            g = last ? 2'b01 : 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/rect_fetch_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant is combinational from req, last winner registered.
// Zero latency; advance is the accept pulse, so an unaccepted grant does not rotate priority.
module rr_arb2
    import rect_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last_grant
);

    always_comb begin
        grant = rr_pick(req, last_grant);
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (advance)
            last_grant <= grant[1];
    end

endmodule

// File: rtl/rect_fetch_ctrl.sv
// Arbitrates two requesters onto one ROM, reads 4 words per feature and returns (x,y,w,h) 5 edges after accept.
// Response stalls on rsp_ready low with no new accepts; RECT_FETCH_BOUNDS_EN adds an out-of-range error path.
module rect_fetch_ctrl
    import rect_fetch_pkg::*;
#(
    parameter int W_DATA = 5,
    parameter int W_ADDR = 14,
    parameter int W_FEAT = 12,
    parameter int N_FEAT = 52
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*W_FEAT-1:0]   req_feat,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [W_DATA-1:0]     rsp_x,
    output logic [W_DATA-1:0]     rsp_y,
    output logic [W_DATA-1:0]     rsp_w,
    output logic [W_DATA-1:0]     rsp_h,
    output logic                  rom_en,
    output logic [W_ADDR-1:0]     rom_addr,
    input  logic [W_DATA-1:0]     rom_data
`ifdef RECT_FETCH_BOUNDS_EN
    ,
    output logic                  rsp_err
`endif
);

    state_t                           state;
    logic [1:0]                       cnt;
    logic [W_ADDR-1:0]                base;
    logic                             id;
    logic [RECT_WORDS-1:0][W_DATA-1:0] fields;

    logic [1:0]        grant;
    logic              last_grant;
    logic              accept;
    logic              acc_id;
    logic [W_FEAT-1:0] acc_feat;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (req_valid),
        .advance    (accept),
        .grant      (grant),
        .last_grant (last_grant)
    );

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst)
            req_ready = grant;
        accept   = |(req_valid & req_ready);
        acc_id   = grant[1];
        acc_feat = req_feat[acc_id*W_FEAT +: W_FEAT];
    end

    always_comb begin
        rom_en   = 1'b0;
        rom_addr = '0;
        if (state == FETCH) begin
            rom_en   = 1'b1;
            rom_addr = base + W_ADDR'(cnt);
        end
    end

    assign rsp_id = id;
    assign rsp_x  = fields[X];
    assign rsp_y  = fields[Y];
    assign rsp_w  = fields[W];
    assign rsp_h  = fields[H];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            id        <= 1'b0;
            fields    <= '0;
            rsp_valid <= 1'b0;
`ifdef RECT_FETCH_BOUNDS_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id   <= acc_id;
                        base <= {acc_feat, 2'b00};
                        cnt  <= '0;
`ifdef RECT_FETCH_BOUNDS_EN
                        if (acc_feat >= W_FEAT'(N_FEAT)) begin
                            fields    <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            rsp_err <= 1'b0;
                            state   <= FETCH;
                        end
`else
                        state <= FETCH;
`endif
                    end
                end
                FETCH: begin
                    // Data for address cnt-1 is on rom_data now.
                    cnt <= cnt + 2'd1;
                    if (cnt != 2'd0)
                        fields[cnt - 2'd1] <= rom_data;
                    if (cnt == 2'd3)
                        state <= DRAIN;
                end
                DRAIN: begin
                    fields[H] <= rom_data;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fetch_ctrl.sv
// Bench for rect_fetch_ctrl: table of spec tuples, reset corner case, random traffic against a timing model.
module tb_rect_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [23:0] req_feat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [4:0]  rsp_x, rsp_y, rsp_w, rsp_h;
    logic        rom_en;
    logic [13:0] rom_addr;
    logic [4:0]  rom_data = '0;
`ifdef RECT_FETCH_BOUNDS_EN
    logic        rsp_err;
`endif

    always #5 clk = ~clk;

    rect_fetch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_feat  (req_feat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_x     (rsp_x),
        .rsp_y     (rsp_y),
        .rsp_w     (rsp_w),
        .rsp_h     (rsp_h),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
`ifdef RECT_FETCH_BOUNDS_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    // ROM: 1-cycle registered read, enable-gated.
    logic [4:0] rom_mem [16384];
    always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level timing rules.
    int   cyc    = 0;
    bit   m_busy = 0;
    bit   m_last = 1;
    bit   m_id   = 0;
    bit   m_oob  = 0;
    int   m_feat = 0;
    int   m_acc  = 0;

    function automatic bit model_valid();
        return m_busy && (cyc >= m_acc + (m_oob ? 1 : 5));
    endfunction

    function automatic int exp_field(input int k);
        return m_oob ? 0 : int'(rom_mem[m_feat*4 + k]);
    endfunction

    task automatic cycle(input logic [1:0] v, input logic [11:0] f0, input logic [11:0] f1,
                         input logic rdy, output bit hs, output logic oid,
                         output logic [4:0] ox, output logic [4:0] oy,
                         output logic [4:0] ow, output logic [4:0] oh);
        logic [1:0] exp_rr;
        bit         exp_v;
        bit         exp_en;
        req_valid = v;
        req_feat  = {f1, f0};
        rsp_ready = rdy;
        #1;
        exp_rr = 2'b00;
        if (!m_busy) exp_rr = (v == 2'b11) ? (m_last ? 2'b01 : 2'b10) : v;
        chk("req_ready", int'(req_ready), int'(exp_rr));
        exp_v = model_valid();
        chk("rsp_valid", int'(rsp_valid), int'(exp_v));
        exp_en = m_busy && !m_oob && cyc >= m_acc && cyc <= m_acc + 3;
        chk("rom_en", int'(rom_en), int'(exp_en));
        if (exp_en) chk("rom_addr", int'(rom_addr), m_feat*4 + (cyc - m_acc));
        if (exp_v) begin
            chk("rsp_id", int'(rsp_id), int'(m_id));
            chk("rsp_x", int'(rsp_x), exp_field(0));
            chk("rsp_y", int'(rsp_y), exp_field(1));
            chk("rsp_w", int'(rsp_w), exp_field(2));
            chk("rsp_h", int'(rsp_h), exp_field(3));
`ifdef RECT_FETCH_BOUNDS_EN
            chk("rsp_err", int'(rsp_err), int'(m_oob));
`endif
        end
        hs  = exp_v && rdy;
        oid = rsp_id;
        ox = rsp_x; oy = rsp_y; ow = rsp_w; oh = rsp_h;
        if (hs) begin
            m_busy = 0;
        end else if (exp_rr != 2'b00) begin
            m_busy = 1;
            m_id   = exp_rr[1];
            m_feat = exp_rr[1] ? int'(f1) : int'(f0);
            m_acc  = cyc + 1;
            m_last = m_id;
`ifdef RECT_FETCH_BOUNDS_EN
            m_oob  = (m_feat >= 52);
`else
            m_oob  = 0;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic [1:0]  v;
        logic [11:0] f0;
        logic [11:0] f1;
        int          hold;
        logic        id;
        logic [4:0]  x, y, w, h;
    } vec_t;

    task automatic run_txn(input vec_t t, input string tag);
        bit         hs;
        logic       oid;
        logic [4:0] ox, oy, ow, oh;
        int         nv;
        bit         done;
        nv   = 0;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            bit pv;
            pv = model_valid();
            cycle(t.v, t.f0, t.f1, pv && (nv >= t.hold), hs, oid, ox, oy, ow, oh);
            if (pv) nv++;
            if (hs) begin
                done = 1;
                chk({tag, "_id"}, int'(oid), int'(t.id));
                chk({tag, "_x"}, int'(ox), int'(t.x));
                chk({tag, "_y"}, int'(oy), int'(t.y));
                chk({tag, "_w"}, int'(ow), int'(t.w));
                chk({tag, "_h"}, int'(oh), int'(t.h));
            end
        end
        if (!done) chk({tag, "_timeout"}, 0, 1);
    endtask

    vec_t vt[6];

    initial begin
        bit         hs;
        logic       oid;
        logic [4:0] ox, oy, ow, oh;
        vec_t       t;

        for (int i = 0; i < 16384; i++) rom_mem[i] = 5'($urandom_range(0, 31));
        rom_mem[0]   = 6; rom_mem[1]   = 4; rom_mem[2]   = 12; rom_mem[3]   = 9;
        rom_mem[4]   = 6; rom_mem[5]   = 4; rom_mem[6]   = 12; rom_mem[7]   = 7;
        rom_mem[8]   = 3; rom_mem[9]   = 9; rom_mem[10]  = 18; rom_mem[11]  = 9;
        rom_mem[204] = 0; rom_mem[205] = 4; rom_mem[206] = 6;  rom_mem[207] = 9;

        vt[0] = '{2'b01, 12'd0, 12'd0,  0, 1'b0, 5'd6, 5'd4, 5'd12, 5'd9};
        vt[1] = '{2'b11, 12'd1, 12'd2,  0, 1'b1, 5'd3, 5'd9, 5'd18, 5'd9};
        vt[2] = '{2'b11, 12'd1, 12'd2,  0, 1'b0, 5'd6, 5'd4, 5'd12, 5'd7};
        vt[3] = '{2'b11, 12'd1, 12'd2,  0, 1'b1, 5'd3, 5'd9, 5'd18, 5'd9};
        vt[4] = '{2'b10, 12'd0, 12'd51, 10, 1'b1, 5'd0, 5'd4, 5'd6, 5'd9};
        vt[5] = '{2'b11, 12'd1, 12'd2,  0, 1'b0, 5'd6, 5'd4, 5'd12, 5'd7};

        // Reset state.
        #12;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_fields", int'({rsp_x, rsp_y, rsp_w, rsp_h}), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_txn(vt[i], $sformatf("vec%0d", i));

        // Reset while the fetch sits at cnt=2; the fetch must vanish.
        for (int i = 0; i < 10; i++)
            if (!(m_busy && cyc == m_acc + 2)) cycle(2'b01, 12'd2, 12'd0, 1'b1, hs, oid, ox, oy, ow, oh);
        chk("rst_reach_cnt2", int'(m_busy && cyc == m_acc + 2), 1);
        req_valid = 2'b11;
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", int'(req_ready), 0);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_rom_en", int'(rom_en), 0);
        chk("mid_rst_rom_addr", int'(rom_addr), 0);
        chk("mid_rst_id_fields", int'({rsp_id, rsp_x, rsp_y, rsp_w, rsp_h}), 0);
        req_valid = 2'b00;
        @(negedge clk) rst = 1'b0;
        m_busy = 0;
        m_last = 1;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 8; i++) cycle(2'b00, 12'd0, 12'd0, 1'b1, hs, oid, ox, oy, ow, oh);
        t = '{2'b11, 12'd0, 12'd2, 0, 1'b0, 5'd6, 5'd4, 5'd12, 5'd9};
        run_txn(t, "post_rst");

`ifdef RECT_FETCH_BOUNDS_EN
        t = '{2'b01, 12'd52, 12'd0, 0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0};
        run_txn(t, "oob52");
        t = '{2'b01, 12'd51, 12'd0, 0, 1'b0, 5'd0, 5'd4, 5'd6, 5'd9};
        run_txn(t, "in51");
`endif

        // Random traffic; feature indices change every cycle so only accept-time values matter.
        for (int i = 0; i < 600; i++) begin
            logic [11:0] f0, f1;
`ifdef RECT_FETCH_BOUNDS_EN
            f0 = 12'($urandom_range(40, 60));
            f1 = 12'($urandom_range(40, 60));
`else
            f0 = 12'($urandom_range(0, 4095));
            f1 = 12'($urandom_range(0, 4095));
`endif
            cycle(2'($urandom_range(0, 3)), f0, f1, ($urandom_range(0, 3) != 0),
                  hs, oid, ox, oy, ow, oh);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
